uart_tx_serializer: RTL and testbench



---
 rtl/uart_tx_serializer.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: byte-wide UART transmitter; 1 start bit, 8 data bits LSB first,
//   optional parity bit, STOP_BITS stop bits; line idles high.
// Latency: tx drops on the accept edge; txBusy spans (9+STOP_BITS)*CLKS_PER_BIT cycles
//   (+CLKS_PER_BIT with parity); txDone pulses on the edge txBusy falls.
// Backpressure: txStart is honoured only while txBusy=0; requests made while busy are
//   dropped (no queueing).
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   txStart    one-cycle send request
//   txData     byte to send, sampled on the accept edge only
//   parityOdd  (only with UART_TX_PARITY_EN) 1 selects odd parity, 0 even
//   txBusy     high from the accept edge through the last stop bit
//   tx         serial line out
//   txDone     one-cycle pulse when the frame completes
//
// Optional feature: define UART_TX_PARITY_EN to add a parity bit after the data bits.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       txStart,
    input  logic [7:0] txData,
`ifdef UART_TX_PARITY_EN
    input  logic       parityOdd,
`endif
    output logic       txBusy,
    output logic       tx,
    output logic       txDone
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t      state, state_n;
    logic [15:0] timer, timer_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shift, shift_n;
    logic        stop_cnt, stop_cnt_n;
    logic        tx_n, busy_n, done_n;
    logic        bit_end;
`ifdef UART_TX_PARITY_EN
    logic        par_bit, par_n;
`endif

    assign bit_end = (timer == BIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            timer    <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
            txBusy   <= 1'b0;
            txDone   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            bit_idx  <= bit_idx_n;
            shift    <= shift_n;
            stop_cnt <= stop_cnt_n;
            tx       <= tx_n;
            txBusy   <= busy_n;
            txDone   <= done_n;
`ifdef UART_TX_PARITY_EN
            par_bit  <= par_n;
`endif
        end
    end

    // Next-state logic computes the registered value of every output, so tx,
    // txBusy and txDone never have a combinational path from the inputs.
    always_comb begin
        state_n    = state;
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        stop_cnt_n = stop_cnt;
        tx_n       = tx;
        busy_n     = txBusy;
        done_n     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n      = par_bit;
`endif
        // The bit timer restarts at every bit boundary and otherwise counts up.
        timer_n    = bit_end ? 16'd0 : timer + 16'd1;

        case (state)
            IDLE: begin
                timer_n = 16'd0;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
                if (txStart && !txBusy) begin
                    // Accept edge: the start bit begins on this very edge.
                    shift_n    = txData;
                    bit_idx_n  = 3'd0;
                    stop_cnt_n = 1'b0;
                    tx_n       = 1'b0;
                    busy_n     = 1'b1;
                    state_n    = START;
`ifdef UART_TX_PARITY_EN
                    par_n      = (^txData) ^ parityOdd;
`endif
                end
            end

            START: begin
                if (bit_end) begin
                    tx_n    = shift[0];
                    state_n = DATA;
                end
            end

            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_n    = par_bit;
                        state_n = PARITY;
`else
                        tx_n    = 1'b1;
                        state_n = STOP;
`endif
                    end else begin
                        // shift[1] is the bit that lands in shift[0] on this edge.
                        shift_n   = {1'b0, shift[7:1]};
                        tx_n      = shift[1];
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    tx_n    = 1'b1;
                    state_n = STOP;
                end
            end
`endif

            STOP: begin
                tx_n = 1'b1;
                if (bit_end) begin
                    // Stop bits are counted one bit-time at a time so the
                    // 16-bit timer never has to span more than one bit.
                    if (stop_cnt == STOP_LAST) begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        stop_cnt_n = stop_cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
                timer_n = 16'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed bench for uart_tx_serializer with CLKS_PER_BIT=4.
// Latency under test: start bit on the accept edge, txBusy for the whole frame.
// Backpressure under test: txStart held high while busy must not queue a frame.
module tb_uart_tx_serializer;

    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       txStart, txStart2;
    logic [7:0] txData, txData2;
    logic       parity_odd;
    logic       txBusy, tx, txDone;
    logic       txBusy2, tx2, txDone2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLKS_PER_BIT(C), .STOP_BITS(1)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .txStart  (txStart),
        .txData   (txData),
`ifdef UART_TX_PARITY_EN
        .parityOdd(parity_odd),
`endif
        .txBusy   (txBusy),
        .tx       (tx),
        .txDone   (txDone)
    );

    uart_tx_serializer #(.CLKS_PER_BIT(C), .STOP_BITS(2)) u_dut2 (
        .clk      (clk),
        .reset    (reset),
        .txStart  (txStart2),
        .txData   (txData2),
`ifdef UART_TX_PARITY_EN
        .parityOdd(parity_odd),
`endif
        .txBusy   (txBusy2),
        .tx       (tx2),
        .txDone   (txDone2)
    );

    task automatic chk(input string tag, input logic got, input logic exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line level for frame bit k of byte d.
    function automatic logic exp_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (PAR == 1 && k == 9) return (^d) ^ parity_odd;
        return 1'b1;
    endfunction

    function automatic logic obs_tx(input int sel);
        return (sel != 0) ? tx2 : tx;
    endfunction
    function automatic logic obs_busy(input int sel);
        return (sel != 0) ? txBusy2 : txBusy;
    endfunction
    function automatic logic obs_done(input int sel);
        return (sel != 0) ? txDone2 : txDone;
    endfunction

    // Starts right after the accept edge; checks every cycle of the frame and
    // the completion cycle (txBusy low, txDone high). Returns at that negedge.
    task automatic frame_body(input int sel, input logic [7:0] d);
        int s = (sel != 0) ? 2 : 1;
        int n = (1 + 8 + PAR + s) * C;
        for (int cyc = 0; cyc < n; cyc++) begin
            @(negedge clk);
            chk("tx_bit", obs_tx(sel), exp_bit(d, cyc / C));
            chk("busy_in_frame", obs_busy(sel), 1'b1);
            chk("done_in_frame", obs_done(sel), 1'b0);
        end
        @(negedge clk);
        chk("busy_fall", obs_busy(sel), 1'b0);
        chk("done_pulse", obs_done(sel), 1'b1);
        chk("tx_idle_after", obs_tx(sel), 1'b1);
    endtask

    // Single-cycle request; txData is scrambled after the accept edge.
    task automatic send(input int sel, input logic [7:0] d);
        @(negedge clk);
        if (sel != 0) begin txStart2 = 1'b1; txData2 = d; end
        else          begin txStart  = 1'b1; txData  = d; end
        @(posedge clk);
        #1;
        if (sel != 0) begin txStart2 = 1'b0; txData2 = ~d; end
        else          begin txStart  = 1'b0; txData  = ~d; end
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        chk(tag, tx, 1'b1);
        chk(tag, txBusy, 1'b0);
        chk(tag, txDone, 1'b0);
    endtask

    initial begin
        reset = 1'b1; txStart = 1'b0; txData = 8'h00;
        txStart2 = 1'b0; txData2 = 8'h00; parity_odd = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state and 20 idle cycles on both instances.
        for (int i = 0; i < 20; i++) begin
            idle_check("reset_idle");
            chk("reset_idle2_tx", tx2, 1'b1);
            chk("reset_idle2_busy", txBusy2, 1'b0);
            chk("reset_idle2_done", txDone2, 1'b0);
        end

        // Basic frame 0x02.
        send(0, 8'h02);
        frame_body(0, 8'h02);
        idle_check("after_02");

        // 0xA5 with txStart held high: second frame one cycle after busy falls.
        @(negedge clk);
        txStart = 1'b1; txData = 8'hA5;
        @(posedge clk);
        #1 txData = 8'h5A;
        frame_body(0, 8'hA5);
        frame_body(0, 8'h5A);
        txStart = 1'b0;
        idle_check("no_third_frame");
        idle_check("no_third_frame");

        // Reset at cycle 13 of a 0xFF frame.
        send(0, 8'hFF);
        for (int cyc = 0; cyc < 13; cyc++) begin
            @(negedge clk);
            chk("ff_tx_bit", tx, exp_bit(8'hFF, cyc / C));
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        idle_check("mid_frame_reset");
        idle_check("mid_frame_reset");
        send(0, 8'h3C);
        frame_body(0, 8'h3C);
        idle_check("after_3c");

        // Two stop bits, 0x00.
        send(1, 8'h00);
        frame_body(1, 8'h00);
        @(negedge clk);
        chk("after_stop2_done", txDone2, 1'b0);
        chk("after_stop2_busy", txBusy2, 1'b0);

`ifdef UART_TX_PARITY_EN
        parity_odd = 1'b0;
        send(0, 8'h07);
        frame_body(0, 8'h07);
        idle_check("after_even_par");
        parity_odd = 1'b1;
        send(0, 8'h07);
        frame_body(0, 8'h07);
        idle_check("after_odd_par");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
